// File: rtl/operand_fetch_if.sv
// Decode-to-execute bundle for the operand fetch stage: request handshake,
// operand/opcode output handshake, writeback port and stall counter.
interface operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [OP_W-1:0]   op_in;
  logic [IMM_W-1:0]  imm_in;
  logic              use_imm;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              ops_equal;
  logic [OP_W-1:0]   op_out;
  logic [ADDR_W-1:0] rd_out;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, rs_addr, rt_addr, rd_addr, op_in, imm_in, use_imm, flush,
    input  out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, opa, opb, ops_equal, op_out, rd_out, stall_cnt
  );

  modport master (
    output in_valid, rs_addr, rt_addr, rd_addr, op_in, imm_in, use_imm, flush,
    output out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, opa, opb, ops_equal, op_out, rd_out, stall_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: 32-entry register file, bypassed operand read, and a
// one-deep output register that stays coherent with writeback while stalled.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regfile_r [NREG];

  logic              out_valid_r, valid_n_s;
  logic [DATA_W-1:0] opa_r, opa_n_s, rd_a_s;
  logic [DATA_W-1:0] opb_r, opb_n_s, rd_b_s;
  logic              eq_r, eq_n_s;
  logic [OP_W-1:0]   op_r, op_n_s;
  logic [ADDR_W-1:0] rd_r, rd_n_s;
  logic [ADDR_W-1:0] rs_r, rs_n_s;
  logic [ADDR_W-1:0] rt_r, rt_n_s;
  logic              uimm_r, uimm_n_s;
  logic [CNT_W-1:0]  stall_r;

  logic in_ready_s, accept_s, hold_s, wb_live_s;

  assign wb_live_s  = bus.wb_en && (bus.wb_addr != ZERO_ADDR);
  assign in_ready_s = !bus.flush && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign hold_s     = out_valid_r && !bus.out_ready && !bus.flush;

  // Register file write port; address 0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regfile_r[i] <= {DATA_W{1'b0}};
    end else if (wb_live_s) begin
      regfile_r[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Source operand read with same-cycle writeback bypass
  always_comb begin
    rd_a_s = {DATA_W{1'b0}};
    rd_b_s = {DATA_W{1'b0}};
    if (bus.rs_addr == ZERO_ADDR) begin
      rd_a_s = {DATA_W{1'b0}};
    end else if (bus.wb_en && (bus.wb_addr == bus.rs_addr)) begin
      rd_a_s = bus.wb_data;
    end else begin
      rd_a_s = regfile_r[bus.rs_addr];
    end
    if (bus.use_imm) begin
      rd_b_s = {{(DATA_W-IMM_W){1'b0}}, bus.imm_in};
    end else if (bus.rt_addr == ZERO_ADDR) begin
      rd_b_s = {DATA_W{1'b0}};
    end else if (bus.wb_en && (bus.wb_addr == bus.rt_addr)) begin
      rd_b_s = bus.wb_data;
    end else begin
      rd_b_s = regfile_r[bus.rt_addr];
    end
  end

  // Output stage next state: flush beats accept beats hold-refresh beats drain
  always_comb begin
    valid_n_s = out_valid_r;
    opa_n_s   = opa_r;
    opb_n_s   = opb_r;
    op_n_s    = op_r;
    rd_n_s    = rd_r;
    rs_n_s    = rs_r;
    rt_n_s    = rt_r;
    uimm_n_s  = uimm_r;
    if (bus.flush) begin
      valid_n_s = 1'b0;
    end else if (accept_s) begin
      valid_n_s = 1'b1;
      opa_n_s   = rd_a_s;
      opb_n_s   = rd_b_s;
      op_n_s    = bus.op_in;
      rd_n_s    = bus.rd_addr;
      rs_n_s    = bus.rs_addr;
      rt_n_s    = bus.rt_addr;
      uimm_n_s  = bus.use_imm;
    end else if (hold_s) begin
      // Held operands track writes to their source registers
      if (wb_live_s && (bus.wb_addr == rs_r)) begin
        opa_n_s = bus.wb_data;
      end else begin
        opa_n_s = opa_r;
      end
      if (wb_live_s && !uimm_r && (bus.wb_addr == rt_r)) begin
        opb_n_s = bus.wb_data;
      end else begin
        opb_n_s = opb_r;
      end
    end else begin
      valid_n_s = 1'b0;
    end
    eq_n_s = (opa_n_s == opb_n_s);
  end

  // Output bundle and held source information
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      opa_r       <= {DATA_W{1'b0}};
      opb_r       <= {DATA_W{1'b0}};
      eq_r        <= 1'b1;
      op_r        <= {OP_W{1'b0}};
      rd_r        <= {ADDR_W{1'b0}};
      rs_r        <= {ADDR_W{1'b0}};
      rt_r        <= {ADDR_W{1'b0}};
      uimm_r      <= 1'b0;
    end else begin
      out_valid_r <= valid_n_s;
      opa_r       <= opa_n_s;
      opb_r       <= opb_n_s;
      eq_r        <= eq_n_s;
      op_r        <= op_n_s;
      rd_r        <= rd_n_s;
      rs_r        <= rs_n_s;
      rt_r        <= rt_n_s;
      uimm_r      <= uimm_n_s;
    end
  end

  // Saturating back-pressure counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (hold_s && (stall_r != {CNT_W{1'b1}})) begin
      stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_r <= stall_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.opa       = opa_r;
  assign bus.opb       = opb_r;
  assign bus.ops_equal = eq_r;
  assign bus.op_out    = op_r;
  assign bus.rd_out    = rd_r;
  assign bus.stall_cnt = stall_r;
endmodule
